// File: rtl/vga_text_pkg.sv
// Shared geometry, control codes and write-sequencer state type for the
// text-mode console writer.
package vga_text_pkg;

    localparam int COLS          = 80;
    localparam int ROWS          = 30;
    localparam int WORDS_PER_ROW = COLS / 4;
    localparam int NUM_WORDS     = ROWS * WORDS_PER_ROW;
    localparam int CTRL_ADDR     = 600;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        COLOR,
        CHAR,
        CLR_ROW,
        CLR_ALL
    } wr_state_t;

endpackage

// File: rtl/text_console_writer_if.sv
// Avalon-MM write-only master bus between the console writer and the
// text-mode controller's register file.
interface text_console_writer_if;

    logic        avm_write;
    logic [9:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_write,
        output avm_address,
        output avm_byteenable,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_write,
        input  avm_address,
        input  avm_byteenable,
        input  avm_writedata,
        output avm_waitrequest
    );

endinterface

// File: rtl/text_console_writer.sv
// Terminal front-end: turns a character byte stream into glyph writes on the
// text controller's register file, tracks an 80x30 cursor, handles LF/CR/BS/FF
// and loads the colour control word.
module text_console_writer #(
    parameter int COLS      = vga_text_pkg::COLS,
    parameter int ROWS      = vga_text_pkg::ROWS,
    parameter int CTRL_ADDR = vga_text_pkg::CTRL_ADDR
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         char_valid,
    input  logic [7:0]                   char_data,
    output logic                         char_ready,
    input  logic                         color_valid,
    input  logic [11:0]                  color_fg,
    input  logic [11:0]                  color_bg,
    output logic                         color_ready,
    text_console_writer_if.master        avm,
    output logic [4:0]                   cursor_row,
    output logic [6:0]                   cursor_col,
    output logic                         busy
);

    import vga_text_pkg::wr_state_t;
    import vga_text_pkg::IDLE;
    import vga_text_pkg::COLOR;
    import vga_text_pkg::CHAR;
    import vga_text_pkg::CLR_ROW;
    import vga_text_pkg::CLR_ALL;
    import vga_text_pkg::LF;
    import vga_text_pkg::CR;
    import vga_text_pkg::BS;
    import vga_text_pkg::FF;

    localparam logic [9:0] WPR10     = 10'(COLS / 4);
    localparam logic [9:0] LAST_WORD = 10'(ROWS * COLS / 4 - 1);
    localparam logic [9:0] CTRL10    = 10'(CTRL_ADDR);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);

    // First word address of a row; constant multiply reduces to shift-add.
    function automatic logic [9:0] row_base(input logic [4:0] r);
        return {5'd0, r} * WPR10;
    endfunction

    wr_state_t   state;

    logic        char_pend;
    logic [7:0]  char_byte;
    logic [4:0]  nxt_row;
    logic [6:0]  nxt_col;
    logic        wrap_pend;
    logic [9:0]  clr_start;
    logic [9:0]  clr_last;

    logic        done;
    logic        color_fire;
    logic        char_fire;
    logic        launch;

    logic [7:0]  sel_byte;
    logic [4:0]  adv_row;
    logic [9:0]  adv_base;
    wr_state_t   l_state;
    logic        l_write;
    logic [9:0]  l_addr;
    logic [3:0]  l_be;
    logic [31:0] l_data;
    logic [4:0]  l_nxt_row;
    logic [6:0]  l_nxt_col;
    logic        l_wrap;
    logic [9:0]  l_last;

    assign char_ready  = (state == IDLE) && !reset;
    assign color_ready = (state == IDLE) && !reset;
    assign busy        = (state != IDLE);

    assign done       = avm.avm_write && !avm.avm_waitrequest;
    assign color_fire = color_valid && color_ready;
    assign char_fire  = char_valid && char_ready;

    // A character operation starts either straight from IDLE or right after
    // the colour write that was accepted together with it.
    assign launch = ((state == IDLE) && char_fire && !color_fire) ||
                    ((state == COLOR) && done && char_pend);

    // Decode the byte being launched against the current cursor.
    always_comb begin
        sel_byte  = (state == COLOR) ? char_byte : char_data;
        adv_row   = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
        adv_base  = row_base(adv_row);
        l_state   = IDLE;
        l_write   = 1'b0;
        l_addr    = adv_base;
        l_be      = 4'hF;
        l_data    = '0;
        l_nxt_row = cursor_row;
        l_nxt_col = cursor_col;
        l_wrap    = 1'b0;
        l_last    = adv_base + (WPR10 - 10'd1);
        if (sel_byte[7] || ((sel_byte >= 8'h20) && (sel_byte != 8'h7F))) begin
            l_state = CHAR;
            l_write = 1'b1;
            l_addr  = row_base(cursor_row) + {5'd0, cursor_col[6:2]};
            l_be    = 4'b0001 << cursor_col[1:0];
            l_data  = {4{sel_byte}};
            if (cursor_col == LAST_COL) begin
                l_nxt_row = adv_row;
                l_nxt_col = 7'd0;
                l_wrap    = 1'b1;
            end else begin
                l_nxt_col = cursor_col + 7'd1;
            end
        end else begin
            case (sel_byte)
                LF: begin
                    l_state   = CLR_ROW;
                    l_write   = 1'b1;
                    l_nxt_row = adv_row;
                    l_nxt_col = 7'd0;
                end
                CR: begin
                    l_state   = CHAR;
                    l_nxt_col = 7'd0;
                end
                BS: begin
                    l_state = CHAR;
                    if (cursor_col != 7'd0) begin
                        l_nxt_col = cursor_col - 7'd1;
                    end
                end
                FF: begin
                    l_state   = CLR_ALL;
                    l_write   = 1'b1;
                    l_addr    = '0;
                    l_nxt_row = 5'd0;
                    l_nxt_col = 7'd0;
                    l_last    = LAST_WORD;
                end
                default: ;
            endcase
        end
    end

    // Write sequencer: colour, glyph and clear writes with registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            avm.avm_write      <= 1'b0;
            avm.avm_address    <= '0;
            avm.avm_byteenable <= '0;
            avm.avm_writedata  <= '0;
            cursor_row         <= '0;
            cursor_col         <= '0;
            char_pend          <= 1'b0;
            char_byte          <= '0;
            nxt_row            <= '0;
            nxt_col            <= '0;
            wrap_pend          <= 1'b0;
            clr_start          <= '0;
            clr_last           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (color_fire) begin
                        state              <= COLOR;
                        avm.avm_write      <= 1'b1;
                        avm.avm_address    <= CTRL10;
                        avm.avm_byteenable <= 4'hF;
                        avm.avm_writedata  <= {7'b0, color_fg, color_bg, 1'b0};
                        char_pend          <= char_fire;
                        char_byte          <= char_data;
                    end
                end
                COLOR: begin
                    if (done && !char_pend) begin
                        state         <= IDLE;
                        avm.avm_write <= 1'b0;
                    end
                end
                CHAR: begin
                    if (!avm.avm_write) begin
                        cursor_row <= nxt_row;
                        cursor_col <= nxt_col;
                        state      <= IDLE;
                    end else if (done) begin
                        if (wrap_pend) begin
                            // Glyph landed in the last column: roll straight into
                            // clearing the new row, keeping the strobe asserted.
                            state              <= CLR_ROW;
                            avm.avm_address    <= clr_start;
                            avm.avm_byteenable <= 4'hF;
                            avm.avm_writedata  <= '0;
                        end else begin
                            cursor_row    <= nxt_row;
                            cursor_col    <= nxt_col;
                            avm.avm_write <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    if (done) begin
                        if (avm.avm_address == clr_last) begin
                            avm.avm_write <= 1'b0;
                            cursor_row    <= nxt_row;
                            cursor_col    <= nxt_col;
                            state         <= IDLE;
                        end else begin
                            avm.avm_address <= avm.avm_address + 10'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (launch) begin
                state         <= l_state;
                avm.avm_write <= l_write;
                if (l_write) begin
                    avm.avm_address    <= l_addr;
                    avm.avm_byteenable <= l_be;
                    avm.avm_writedata  <= l_data;
                end
                nxt_row   <= l_nxt_row;
                nxt_col   <= l_nxt_col;
                wrap_pend <= l_wrap;
                clr_start <= adv_base;
                clr_last  <= l_last;
                char_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer.
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        color_valid;
    logic [11:0] color_fg;
    logic [11:0] color_bg;
    logic        color_ready;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    text_console_writer_if bus ();

    text_console_writer dut (
        .clk         (clk),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .color_valid (color_valid),
        .color_fg    (color_fg),
        .color_bg    (color_bg),
        .color_ready (color_ready),
        .avm         (bus),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit stall_en = 1'b0;

    logic [9:0]  qa[$];
    logic [3:0]  qb[$];
    logic [31:0] qd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random slave stalls, enabled only for selected steps.
    initial begin
        bus.avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Bus monitor: log completed writes, check stability across stalls.
    logic        stalled_q = 1'b0;
    logic [9:0]  sa;
    logic [3:0]  sb;
    logic [31:0] sd;
    always @(negedge clk) begin
        if (!reset && bus.avm_write) begin
            if (stalled_q) begin
                chk("stall_addr", 32'(bus.avm_address), 32'(sa));
                chk("stall_be", 32'(bus.avm_byteenable), 32'(sb));
                chk("stall_data", bus.avm_writedata, sd);
            end
            if (!bus.avm_waitrequest) begin
                qa.push_back(bus.avm_address);
                qb.push_back(bus.avm_byteenable);
                qd.push_back(bus.avm_writedata);
            end
        end
        stalled_q = !reset && bus.avm_write && bus.avm_waitrequest;
        sa = bus.avm_address;
        sb = bus.avm_byteenable;
        sd = bus.avm_writedata;
    end

    task automatic qclear();
        qa.delete();
        qb.delete();
        qd.delete();
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (busy && lat < 5000);
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input logic with_color, output int lat);
        @(posedge clk);
        #1;
        char_valid  = 1'b1;
        char_data   = b;
        color_valid = with_color;
        chk("ready_at_send", 32'(char_ready), 32'd1);
        @(posedge clk);
        #1;
        char_valid  = 1'b0;
        color_valid = 1'b0;
        wait_idle(lat);
    endtask

    task automatic chk_cursor(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(cursor_row), 32'(r));
        chk({tag, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    task automatic chk_clears(input string tag, input int first, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (first + i < qa.size()) begin
                chk({tag, "_addr"}, 32'(qa[first + i]), 32'(base + i));
                chk({tag, "_be"}, 32'(qb[first + i]), 32'hF);
                chk({tag, "_data"}, qd[first + i], 32'h0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int snap;

        reset       = 1'b1;
        char_valid  = 1'b0;
        char_data   = '0;
        color_valid = 1'b0;
        color_fg    = '0;
        color_bg    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_write", 32'(bus.avm_write), 32'd0);
        chk("rst_addr", 32'(bus.avm_address), 32'd0);
        chk("rst_be", 32'(bus.avm_byteenable), 32'd0);
        chk("rst_data", bus.avm_writedata, 32'd0);
        chk_cursor("rst", 0, 0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_char_ready", 32'(char_ready), 32'd0);
        chk("rst_color_ready", 32'(color_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_char_ready", 32'(char_ready), 32'd1);
        chk("post_rst_color_ready", 32'(color_ready), 32'd1);

        // 'A' at (0,0)
        qclear();
        send(8'h41, 1'b0, lat);
        chk("A_lat", 32'(lat), 32'd2);
        chk("A_count", 32'(qa.size()), 32'd1);
        if (qa.size() > 0) begin
            chk("A_addr", 32'(qa[0]), 32'd0);
            chk("A_be", 32'(qb[0]), 32'h1);
            chk("A_data", qd[0], 32'h41414141);
        end
        chk_cursor("A", 0, 1);

        // 'B' at (0,1) lands in lane 1
        qclear();
        send(8'h42, 1'b0, lat);
        chk("B_count", 32'(qa.size()), 32'd1);
        if (qa.size() > 0) begin
            chk("B_be", 32'(qb[0]), 32'h2);
            chk("B_data", qd[0], 32'h42424242);
        end
        chk_cursor("B", 0, 2);

        // BS from col 2, CR from col 1, discarded control byte
        qclear();
        send(8'h08, 1'b0, lat);
        chk_cursor("BS", 0, 1);
        send(8'h0D, 1'b0, lat);
        chk("CR_lat", 32'(lat), 32'd2);
        chk_cursor("CR", 0, 0);
        send(8'h01, 1'b0, lat);
        chk("nop_lat", 32'(lat), 32'd1);
        chk_cursor("nop", 0, 0);
        chk("ctrl_no_writes", 32'(qa.size()), 32'd0);

        // two LFs clear rows 1 and 2
        qclear();
        send(8'h0A, 1'b0, lat);
        chk("LF1_lat", 32'(lat), 32'd21);
        chk("LF1_count", 32'(qa.size()), 32'd20);
        chk_clears("LF1", 0, 20, 20);
        chk_cursor("LF1", 1, 0);
        send(8'h0A, 1'b0, lat);
        chk_cursor("LF2", 2, 0);

        // fill row 2 up to col 79, then 'Z' wraps
        for (int i = 0; i < 79; i++) send(8'h78, 1'b0, lat);
        chk_cursor("fill", 2, 79);
        qclear();
        send(8'h5A, 1'b0, lat);
        chk("Z_lat", 32'(lat), 32'd22);
        chk("Z_count", 32'(qa.size()), 32'd21);
        if (qa.size() > 0) begin
            chk("Z_addr", 32'(qa[0]), 32'd59);
            chk("Z_be", 32'(qb[0]), 32'h8);
            chk("Z_data", qd[0], 32'h5A5A5A5A);
        end
        chk_clears("Z_clr", 1, 60, 20);
        chk_cursor("Z", 3, 0);

        // walk down to (29,5), LF wraps to row 0
        for (int i = 0; i < 26; i++) send(8'h0A, 1'b0, lat);
        for (int i = 0; i < 5; i++) send(8'h79, 1'b0, lat);
        chk_cursor("bottom", 29, 5);
        qclear();
        send(8'h0A, 1'b0, lat);
        chk("LFwrap_count", 32'(qa.size()), 32'd20);
        chk_clears("LFwrap", 0, 0, 20);
        chk_cursor("LFwrap", 0, 0);
        qclear();
        send(8'h08, 1'b0, lat);
        chk("BS0_count", 32'(qa.size()), 32'd0);
        chk_cursor("BS0", 0, 0);

        // colour and character accepted together
        color_fg = 12'hFFF;
        color_bg = 12'h00F;
        qclear();
        send(8'hC1, 1'b1, lat);
        chk("CC_lat", 32'(lat), 32'd3);
        chk("CC_count", 32'(qa.size()), 32'd2);
        if (qa.size() > 1) begin
            chk("CC_color_addr", 32'(qa[0]), 32'd600);
            chk("CC_color_be", 32'(qb[0]), 32'hF);
            chk("CC_color_data", qd[0], 32'h01FFE01E);
            chk("CC_glyph_addr", 32'(qa[1]), 32'd0);
            chk("CC_glyph_be", 32'(qb[1]), 32'h1);
            chk("CC_glyph_data", qd[1], 32'hC1C1C1C1);
        end
        chk_cursor("CC", 0, 1);

        // FF with random stalls
        qclear();
        stall_en = 1'b1;
        send(8'h0C, 1'b0, lat);
        stall_en = 1'b0;
        chk("FF_count", 32'(qa.size()), 32'd600);
        chk_clears("FF", 0, 0, 600);
        chk_cursor("FF", 0, 0);

        // reset in the middle of a full clear
        repeat (3) @(negedge clk);
        qclear();
        @(posedge clk);
        #1;
        char_valid = 1'b1;
        char_data  = 8'h0C;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.avm_write && bus.avm_address == 10'd300) && n < 1000);
        chk("abort_reach_300", 32'(bus.avm_address), 32'd300);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_write_low", 32'(bus.avm_write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        snap = qa.size();
        chk("abort_logged", 32'(snap), 32'd301);
        chk("abort_char_ready", 32'(char_ready), 32'd1);
        repeat (30) @(negedge clk);
        chk("abort_no_more", 32'(qa.size()), 32'(snap));
        chk_cursor("abort", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Hardware terminal front-end that turns a byte stream of ASCII characters into Avalon-MM writes to the VGA text-mode controller's register file (600 character words of 4 glyphs each, plus the colour control word at 600). It tracks an 80×30 cursor and interprets LF, CR, BS and FF. Row advance wraps from row 29 to row 0 and blanks the entered row. It also loads the foreground/background colours. It sits directly upstream of the text-mode controller's Avalon slave port, as an alternative to CPU-driven writes.

## Interface
- `COLS`, default 80: characters per row; multiple of 4.
- `ROWS`, default 30: rows on screen.
- `CTRL_ADDR`, default 600: word address of the colour control register.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `char_valid`  in  1  `char_data` is valid.
- `char_data`  in  8  character byte. Bit 7 set selects the inverse glyph; such bytes are never treated as control codes.
- `char_ready`  out  1  the block accepts a character this cycle.
- `color_valid`  in  1  colour update request.
- `color_fg`, `color_bg`  in  12 each  RGB444 foreground and background colours.
- `color_ready`  out  1  the block accepts a colour update this cycle.
- `avm_write`  out  1  Avalon write strobe.
- `avm_address`  out  10  word address.
- `avm_byteenable`  out  4  byte lane enables.
- `avm_writedata`  out  32  write data.
- `avm_waitrequest`  in  1  slave stall; tie to 0 for the text controller.
- `cursor_row`  out  5  current cursor row, 0..ROWS-1.
- `cursor_col`  out  7  current cursor column, 0..COLS-1.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE
  - COLOR: one colour write.
  - CHAR: one glyph write.
  - CLR_ROW: COLS/4 word writes.
  - CLR_ALL: ROWS·COLS/4 word writes.
- Handshakes:
  - `char_ready` = `color_ready` = (state==IDLE) && !reset.
  - A transfer is accepted on valid && ready.
  - If both transfers are accepted in the same cycle, both are latched and COLOR executes before the character.
- Glyph address:
  - word = row·(COLS/4) + col[6:2].
  - byteenable = one-hot of col[1:0].
  - writedata = char replicated into all 4 lanes.
- Colour word: {7'b0, fg, bg, 1'b0} written to CTRL_ADDR, byteenable 4'hF.
- Printable byte (0x20..0x7E, or any byte ≥0x80):
  - CHAR write, then col+1.
  - If col was COLS-1: col=0 and advance row.
- Control bytes (bit 7 = 0):
  - 0x0A LF: col=0, advance row. No glyph write.
  - 0x0D CR: col=0. No write; return to IDLE the next cycle.
  - 0x08 BS: if col>0, col−1; at col 0, no change. No write.
  - 0x0C FF: CLR_ALL, writing 0 to words 0..599, then cursor=(0,0).
  - All other bytes 0x00..0x1F and 0x7F: discarded without effect.
- Advance row:
  - row = (row==ROWS-1) ? 0 : row+1.
  - Then CLR_ROW writes 32'h0 with byteenable 4'hF to all COLS/4 words of the new row. This clear runs on every row advance, wrapped or not.
- Cursor outputs update in the cycle the last write of the operation completes.
- Arithmetic: row·20 uses (row<<4)+(row<<2), width 10 bits; the maximum word address is 599.

## Timing
- A write completes on a cycle with avm_write && !avm_waitrequest. Address, data and byteenable are held stable while waitrequest is high.
- During a multi-word clear, avm_write stays high; the address increments on each completion.
- With waitrequest=0:
  - Printable character accepted at T: write at T+1, char_ready high at T+2.
  - Character causing row advance: glyph at T+1, clears at T+2..T+21, ready at T+22.
  - LF: clears at T+1..T+20, ready at T+21.
  - FF: 600 writes at T+1..T+600, ready at T+601.
  - COLOR: write at T+1, ready at T+2. With a simultaneous character, the glyph write follows at T+2.
- Reset values: avm_write 0, avm_address 0, avm_byteenable 0, avm_writedata 0, cursor (0,0), busy 0, state IDLE, latched requests cleared.
- Reset mid-operation: the sequence is abandoned, avm_write is low after the reset edge, and no remaining clears are issued.

## Structure
- Package `vga_text_pkg` holds:
  - COLS, ROWS, WORDS_PER_ROW=20, NUM_WORDS=600, CTRL_ADDR=600.
  - Control codes LF, CR, BS, FF.
  - The `wr_state_t` enum.
- No sub-module; a single FSM with one word counter (10 bits) drives both clear states.

## Test plan
- Reset, then send 'A' (0x41) with cursor at (0,0): one write to address 0, byteenable 0001, writedata 0x41414141; cursor becomes (0,1).
- Send 'Z' at (2,79): write to address 59, byteenable 1000; then 20 zero writes to addresses 60..79; cursor becomes (3,0).
- Send LF at (29,5): 20 zero writes to addresses 0..19; cursor becomes (0,0). Then BS at col 0: no write, cursor unchanged.
- Raise color_valid and char_valid (0xC1) together, with fg=0xFFF, bg=0x00F:
  - first, a write of 0x01FFE01E to address 600;
  - then a write of 0xC1C1C1C1 to address 0, byteenable 0001.
- Send FF with avm_waitrequest randomly stalling:
  - exactly 600 zero writes to addresses 0..599, in order;
  - signals stable while stalled;
  - cursor becomes (0,0).
- Assert reset during CLR_ALL at address 300: avm_write is 0 the next cycle, no further writes occur, and char_ready is 1 after reset is released.
